// File: rtl/qsm_pkg.sv
// qsm_pkg: shared types and constants for the QSPI DIM readout engine.
//   t_qsm_state  - readout engine state encoding
//   WORD_BITS    - bits shifted in per device per register
//   MEM_AW       - readout DPRAM word address width
//   eff_max_dim  - maps a configured device limit of 0 to 1
package qsm_pkg;

    localparam int unsigned WORD_BITS = 16;
    localparam int unsigned MEM_AW    = 7;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StCsSetup,
        StShiftHi,
        StShiftLo,
        StWordEnd,
        StGap,
        StFinish
    } t_qsm_state;

    function automatic logic [3:0] eff_max_dim(input logic [3:0] max_dim);
        return (max_dim == 4'd0) ? 4'd1 : max_dim;
    endfunction

endpackage

// File: rtl/qsm_us_tick.sv
// qsm_us_tick: 1-us tick prescaler.
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset
//   clr_i  - synchronous clear; holds the prescaler at the start of a microsecond
//   tick_o - one-cycle pulse on the last clock of every DIV-cycle period
module qsm_us_tick #(
    parameter int unsigned DIV = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = !clr_i && (cnt_q == CntLast);

endmodule

// File: rtl/qsm_dim_reader.sv
// qsm_dim_reader: QSPI master engine for one daisy-chained DIM chain.
//   ctrl_*_i      - trigger/reset pulses and run configuration (latched on trigger)
//   stat_*_o      - busy/done/error flags and device count of frame 0
//   mem_*_o       - write port into the readout DPRAM (one word per device per register)
//   qspi_sck_o    - serial clock, idles low
//   qspi_cs_n_o   - frame select, active low, idles high
//   qspi_data_i   - serial data from the chain (asynchronous)
//   qspi_fb_i     - chain feedback, 1 = another device follows (asynchronous)
module qsm_dim_reader
    import qsm_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned SCK_HALF    = 25,
    parameter int unsigned RESET_US    = 1000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ctrl_reset_i,
    input  logic                 ctrl_trig_i,
    input  logic [3:0]           ctrl_last_reg_adr_i,
    input  logic [3:0]           ctrl_max_dim_no_i,
    input  logic [9:0]           ctrl_read_delay_i,
    output logic                 stat_busy_o,
    output logic                 stat_done_o,
    output logic                 stat_err_many_o,
    output logic                 stat_err_fb_o,
    output logic [3:0]           stat_dim_count_o,
    output logic                 mem_we_o,
    output logic [MEM_AW-1:0]    mem_addr_o,
    output logic [WORD_BITS-1:0] mem_data_o,
    output logic                 qspi_sck_o,
    output logic                 qspi_cs_n_o,
    input  logic                 qspi_data_i,
    input  logic                 qspi_fb_i
);

    localparam int unsigned ClkMhz = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned HalfW  = $clog2(SCK_HALF);
    localparam logic [HalfW-1:0] HalfLast = HalfW'(SCK_HALF - 1);
    localparam logic [31:0] RstUsLast = 32'(RESET_US - 1);
    localparam logic [3:0] BitLast = 4'(WORD_BITS - 1);

    t_qsm_state state_q;

    logic                 busy_q, done_q, err_many_q, err_fb_q;
    logic [3:0]           dim_count_q;
    logic                 mem_we_q;
    logic [MEM_AW-1:0]    mem_addr_q;
    logic [WORD_BITS-1:0] mem_data_q;
    logic                 sck_q, cs_n_q;

    logic [3:0]           last_reg_q, max_dim_q;
    logic [9:0]           read_delay_q;
    logic [HalfW-1:0]     half_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [3:0]           dev_cnt_q;
    logic [3:0]           reg_idx_q;
    // One extra bit so the counter can sit at 128 and block further writes.
    logic [MEM_AW:0]      word_cnt_q;
    logic [31:0]          us_cnt_q;
    logic [WORD_BITS-1:0] shreg_q;

    logic data_s1_q, data_s_q, fb_s1_q, fb_s_q;

    logic       us_tick;
    logic       half_done;
    logic [3:0] dev_next;
    logic       gap_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_s1_q <= 1'b0;
            data_s_q  <= 1'b0;
            fb_s1_q   <= 1'b0;
            fb_s_q    <= 1'b0;
        end else begin
            data_s1_q <= qspi_data_i;
            data_s_q  <= data_s1_q;
            fb_s1_q   <= qspi_fb_i;
            fb_s_q    <= fb_s1_q;
        end
    end

    // Prescaler only runs while a microsecond-timed state is active, so it
    // restarts from zero on every GAP/RST entry.
    qsm_us_tick #(
        .DIV (ClkMhz)
    ) u_us_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (!(state_q == StGap || state_q == StRst)),
        .tick_o (us_tick)
    );

    assign half_done = (half_cnt_q == HalfLast);
    assign dev_next  = dev_cnt_q + 4'd1;
    assign gap_done  = (read_delay_q == 10'd0) ||
                       (us_tick && ((us_cnt_q + 32'd1) == {22'd0, read_delay_q}));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_many_q   <= 1'b0;
            err_fb_q     <= 1'b0;
            dim_count_q  <= 4'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            sck_q        <= 1'b0;
            cs_n_q       <= 1'b1;
            last_reg_q   <= 4'd0;
            max_dim_q    <= 4'd1;
            read_delay_q <= 10'd0;
            half_cnt_q   <= '0;
            bit_cnt_q    <= 4'd0;
            dev_cnt_q    <= 4'd0;
            reg_idx_q    <= 4'd0;
            word_cnt_q   <= '0;
            us_cnt_q     <= '0;
            shreg_q      <= '0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ctrl_reset_i) begin
                        state_q  <= StRst;
                        busy_q   <= 1'b1;
                        sck_q    <= 1'b1;
                        cs_n_q   <= 1'b0;
                        us_cnt_q <= '0;
                    end else if (ctrl_trig_i) begin
                        state_q      <= StCsSetup;
                        busy_q       <= 1'b1;
                        cs_n_q       <= 1'b0;
                        half_cnt_q   <= '0;
                        last_reg_q   <= ctrl_last_reg_adr_i;
                        max_dim_q    <= eff_max_dim(ctrl_max_dim_no_i);
                        read_delay_q <= ctrl_read_delay_i;
                        done_q       <= 1'b0;
                        err_many_q   <= 1'b0;
                        err_fb_q     <= 1'b0;
                        word_cnt_q   <= '0;
                        reg_idx_q    <= 4'd0;
                        dev_cnt_q    <= 4'd0;
                        bit_cnt_q    <= 4'd0;
                    end
                end
                StRst: begin
                    if (us_tick && us_cnt_q == RstUsLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        sck_q   <= 1'b0;
                        cs_n_q  <= 1'b1;
                    end else if (us_tick) begin
                        us_cnt_q <= us_cnt_q + 32'd1;
                    end
                end
                StCsSetup: begin
                    if (half_done) begin
                        state_q    <= StShiftHi;
                        sck_q      <= 1'b1;
                        half_cnt_q <= '0;
                    end else begin
                        half_cnt_q <= half_cnt_q + 1'b1;
                    end
                end
                StShiftHi: begin
                    if (half_done) begin
                        state_q    <= StShiftLo;
                        sck_q      <= 1'b0;
                        half_cnt_q <= '0;
                        shreg_q    <= {shreg_q[WORD_BITS-2:0], data_s_q};
                    end else begin
                        half_cnt_q <= half_cnt_q + 1'b1;
                    end
                end
                StShiftLo: begin
                    if (half_done) begin
                        half_cnt_q <= '0;
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BitLast) begin
                            state_q    <= StWordEnd;
                            mem_we_q   <= !word_cnt_q[MEM_AW];
                            mem_addr_q <= word_cnt_q[MEM_AW-1:0];
                            mem_data_q <= shreg_q;
                        end else begin
                            state_q <= StShiftHi;
                            sck_q   <= 1'b1;
                        end
                    end else begin
                        half_cnt_q <= half_cnt_q + 1'b1;
                    end
                end
                StWordEnd: begin
                    if (!word_cnt_q[MEM_AW]) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                    dev_cnt_q <= dev_next;
                    if (fb_s_q && dev_next < max_dim_q) begin
                        state_q    <= StShiftHi;
                        sck_q      <= 1'b1;
                        half_cnt_q <= '0;
                    end else begin
                        // End of frame; fb still high here means the chain is longer than allowed.
                        if (fb_s_q) begin
                            err_many_q <= 1'b1;
                        end
                        cs_n_q <= 1'b1;
                        if (reg_idx_q == 4'd0) begin
                            dim_count_q <= dev_next;
                        end else if (dev_next != dim_count_q) begin
                            err_fb_q <= 1'b1;
                        end
                        if (reg_idx_q == last_reg_q) begin
                            state_q <= StFinish;
                        end else begin
                            state_q  <= StGap;
                            us_cnt_q <= '0;
                        end
                    end
                end
                StGap: begin
                    if (gap_done) begin
                        state_q    <= StCsSetup;
                        cs_n_q     <= 1'b0;
                        half_cnt_q <= '0;
                        reg_idx_q  <= reg_idx_q + 4'd1;
                        dev_cnt_q  <= 4'd0;
                        bit_cnt_q  <= 4'd0;
                    end else if (us_tick) begin
                        us_cnt_q <= us_cnt_q + 32'd1;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    sck_q   <= 1'b0;
                    cs_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign stat_busy_o      = busy_q;
    assign stat_done_o      = done_q;
    assign stat_err_many_o  = err_many_q;
    assign stat_err_fb_o    = err_fb_q;
    assign stat_dim_count_o = dim_count_q;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_data_o       = mem_data_q;
    assign qspi_sck_o       = sck_q;
    assign qspi_cs_n_o      = cs_n_q;

endmodule

// File: tb/tb_qsm_dim_reader.sv
// tb_qsm_dim_reader: bench for qsm_dim_reader with a daisy-chain device model
// and a frame-level reference model of the expected DPRAM writes and flags.
module tb_qsm_dim_reader;

    localparam int unsigned ClkHz   = 100_000_000;
    localparam int unsigned SckHalf = 4;
    localparam int unsigned ResetUs = 10;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        ctrl_reset = 1'b0;
    logic        ctrl_trig = 1'b0;
    logic [3:0]  ctrl_last_reg = 4'd0;
    logic [3:0]  ctrl_max_dim = 4'd0;
    logic [9:0]  ctrl_delay = 10'd0;
    logic        busy, done, err_many, err_fb;
    logic [3:0]  dim_count;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_data;
    logic        qspi_sck, qspi_cs_n;
    logic        qspi_data = 1'b0;
    logic        qspi_fb = 1'b0;

    always #5 clk = ~clk;

    qsm_dim_reader #(
        .CLK_FREQ_HZ (ClkHz),
        .SCK_HALF    (SckHalf),
        .RESET_US    (ResetUs)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .ctrl_reset_i        (ctrl_reset),
        .ctrl_trig_i         (ctrl_trig),
        .ctrl_last_reg_adr_i (ctrl_last_reg),
        .ctrl_max_dim_no_i   (ctrl_max_dim),
        .ctrl_read_delay_i   (ctrl_delay),
        .stat_busy_o         (busy),
        .stat_done_o         (done),
        .stat_err_many_o     (err_many),
        .stat_err_fb_o       (err_fb),
        .stat_dim_count_o    (dim_count),
        .mem_we_o            (mem_we),
        .mem_addr_o          (mem_addr),
        .mem_data_o          (mem_data),
        .qspi_sck_o          (qspi_sck),
        .qspi_cs_n_o         (qspi_cs_n),
        .qspi_data_i         (qspi_data),
        .qspi_fb_i           (qspi_fb)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] word_of(input int r, input int d);
        return 16'(32'hA500 + 16 * r + d);
    endfunction

    // Devices present per register frame, set by the stimulus.
    int ndev_tab [16];

    // Chain model: first device's MSB appears after CS falls, each SCK fall
    // advances one bit, fb reports whether a device follows the word just shifted.
    int   bfm_reg = -1;
    int   bfm_dev = 0;
    int   bfm_bit = 0;
    logic bfm_cs_prev = 1'b1;
    logic bfm_sck_prev = 1'b0;

    function automatic logic bfm_bit_val(input int r, input int d, input int b);
        logic [15:0] w;
        if (r < 0 || r > 15 || d >= ndev_tab[r]) return 1'b0;
        w = word_of(r, d);
        return w[15 - b];
    endfunction

    always @(negedge clk) begin
        if (!busy) begin
            bfm_reg = -1;
        end else if (bfm_cs_prev && !qspi_cs_n) begin
            bfm_reg   = bfm_reg + 1;
            bfm_dev   = 0;
            bfm_bit   = 0;
            qspi_data = bfm_bit_val(bfm_reg, 0, 0);
        end else if (!qspi_cs_n && bfm_sck_prev && !qspi_sck) begin
            bfm_bit = bfm_bit + 1;
            if (bfm_bit == 16) begin
                qspi_fb = (bfm_reg >= 0 && bfm_reg <= 15) ? (bfm_dev + 1 < ndev_tab[bfm_reg]) : 1'b0;
                bfm_dev = bfm_dev + 1;
                bfm_bit = 0;
            end
            qspi_data = bfm_bit_val(bfm_reg, bfm_dev, bfm_bit);
        end
        bfm_cs_prev  = qspi_cs_n;
        bfm_sck_prev = qspi_sck;
    end

    // Expected write stream, filled by the reference model, consumed here.
    logic [6:0]  exp_addr_q [$];
    logic [15:0] exp_data_q [$];
    int          exp_gap = 1;
    int          wr_total = 0;
    int          last_gap = 0;
    int          hi_len = 0;
    logic [15:0] cap_data [128];

    always @(negedge clk) begin
        if (!rst_i) begin
            if (mem_we) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required=no write",
                             mem_addr, mem_data);
                end else begin
                    check("write_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                    check("write_data", 32'(mem_data), 32'(exp_data_q.pop_front()));
                end
                cap_data[mem_addr] = mem_data;
                wr_total++;
            end
            if (!busy) begin
                check("idle_lines", {30'd0, qspi_sck, qspi_cs_n}, 32'd1);
                hi_len = 0;
            end else if (qspi_cs_n) begin
                hi_len++;
            end else if (hi_len > 0) begin
                check("frame_gap", 32'(hi_len), 32'(exp_gap));
                last_gap = hi_len;
                hi_len = 0;
            end
        end
    end

    int wr_start = 0;

    // Reference model: one frame per register, min(chain, limit) words per frame,
    // sequential addresses, only the first 128 words land in memory.
    task automatic run(input int last_reg, input int maxd, input int delay, input bit poke);
        int  maxe, addr, n0, nr, cyc;
        bit  em, ef;
        exp_addr_q.delete();
        exp_data_q.delete();
        maxe = (maxd == 0) ? 1 : maxd;
        addr = 0; n0 = 0; em = 0; ef = 0;
        for (int r = 0; r <= last_reg; r++) begin
            nr = (ndev_tab[r] < maxe) ? ndev_tab[r] : maxe;
            if (ndev_tab[r] > maxe) em = 1;
            if (r == 0) n0 = nr;
            else if (nr != n0) ef = 1;
            for (int d = 0; d < nr; d++) begin
                if (addr < 128) begin
                    exp_addr_q.push_back(7'(addr));
                    exp_data_q.push_back(word_of(r, d));
                end
                addr++;
            end
        end
        exp_gap  = (delay == 0) ? 1 : delay * int'(ClkHz / 1_000_000);
        wr_start = wr_total;

        @(negedge clk);
        ctrl_last_reg = 4'(last_reg);
        ctrl_max_dim  = 4'(maxd);
        ctrl_delay    = 10'(delay);
        ctrl_trig     = 1'b1;
        @(negedge clk);
        ctrl_trig = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("cs_fall", {31'd0, qspi_cs_n}, 32'd0);
        // Config changes mid-run must not matter.
        ctrl_last_reg = 4'($urandom);
        ctrl_max_dim  = 4'($urandom);
        ctrl_delay    = 10'($urandom);
        cyc = 0;
        while (busy && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 300) begin
                ctrl_trig  = 1'b1;
                ctrl_reset = 1'b1;
            end else begin
                ctrl_trig  = 1'b0;
                ctrl_reset = 1'b0;
            end
        end
        ctrl_trig  = 1'b0;
        ctrl_reset = 1'b0;
        check("run_timeout", {31'd0, busy}, 32'd0);
        check("writes_missing", 32'(exp_addr_q.size()), 32'd0);
        check("write_count", 32'(wr_total - wr_start), 32'((addr < 128) ? addr : 128));
        check("done", {31'd0, done}, 32'd1);
        check("err_many", {31'd0, err_many}, {31'd0, em});
        check("err_fb", {31'd0, err_fb}, {31'd0, ef});
        check("dim_count", 32'(dim_count), 32'(n0));
    endtask

    initial begin
        int cyc, rst_len;
        for (int i = 0; i < 16; i++) ndev_tab[i] = 1;

        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_errs", {30'd0, err_many, err_fb}, 32'd0);
        check("reset_count", 32'(dim_count), 32'd0);
        check("reset_mem", {7'd0, mem_we, mem_addr, mem_data}, 32'd0);
        check("reset_qspi", {30'd0, qspi_sck, qspi_cs_n}, 32'd1);

        // Three devices, two registers, 2 us gap.
        ndev_tab[0] = 3; ndev_tab[1] = 3;
        run(1, 4, 2, 1'b0);
        check("pin_w0", 32'(cap_data[0]), 32'h0000A500);
        check("pin_w3", 32'(cap_data[3]), 32'h0000A510);
        check("pin_w5", 32'(cap_data[5]), 32'h0000A512);
        check("pin_gap", 32'(last_gap), 32'd200);
        check("pin_dim3", 32'(dim_count), 32'd3);

        // DIM reset state: sck high, cs low for exactly 10 us.
        @(negedge clk);
        ctrl_reset = 1'b1;
        @(negedge clk);
        ctrl_reset = 1'b0;
        rst_len = 0; cyc = 0;
        while (busy && cyc < 5000) begin
            if (qspi_sck && !qspi_cs_n) rst_len++;
            @(negedge clk);
            cyc++;
        end
        check("rst_len", 32'(rst_len), 32'd1000);
        check("rst_done_kept", {31'd0, done}, 32'd1);

        // Chain longer than the limit.
        ndev_tab[0] = 6; ndev_tab[1] = 6;
        run(1, 4, 1, 1'b0);
        check("pin_many", {31'd0, err_many}, 32'd1);
        check("pin_dim4", 32'(dim_count), 32'd4);

        // Frame device count mismatch, with ignored pulses while busy.
        ndev_tab[0] = 3; ndev_tab[1] = 2;
        run(1, 4, 0, 1'b1);
        check("pin_fb", {31'd0, err_fb}, 32'd1);
        check("pin_wr5", 32'(wr_total - wr_start), 32'd5);

        // Synchronous reset in the middle of shifting.
        exp_addr_q.delete();
        exp_data_q.delete();
        ndev_tab[0] = 3;
        @(negedge clk);
        ctrl_last_reg = 4'd0; ctrl_max_dim = 4'd4; ctrl_trig = 1'b1;
        @(negedge clk);
        ctrl_trig = 1'b0;
        cyc = 0;
        while (!(qspi_sck && !qspi_cs_n) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("shift_reached", {31'd0, qspi_sck}, 32'd1);
        repeat (10) @(negedge clk);
        wr_start = wr_total;
        rst_i = 1'b1;
        @(negedge clk);
        check("abort_state", {28'd0, busy, qspi_cs_n, qspi_sck, done}, 32'h4);
        rst_i = 1'b0;
        repeat (2000) @(negedge clk);
        check("abort_no_write", 32'(wr_total - wr_start), 32'd0);

        // 16 registers of 15 devices: memory saturates at 128 words.
        for (int i = 0; i < 16; i++) ndev_tab[i] = 15;
        run(15, 15, 0, 1'b0);
        check("pin_sat_last", 32'(cap_data[127]), 32'h0000A587);
        check("pin_sat_count", 32'(wr_total - wr_start), 32'd128);

        // Randomised chains and limits.
        for (int k = 0; k < 5; k++) begin
            int lr;
            lr = int'($urandom_range(0, 2));
            for (int i = 0; i < 16; i++) ndev_tab[i] = int'($urandom_range(1, 5));
            run(lr, int'($urandom_range(0, 5)), int'($urandom_range(0, 1)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
